// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: RS tag encoding, CDB payload and sizing constants.
package cdb_arbiter_pkg;

   localparam int unsigned NUM_RS     = 6;
   localparam int unsigned TAG_W      = 3;
   localparam int unsigned CDB_DATA_W = 32;

   typedef enum logic [TAG_W-1:0] {
      STORE_1 = 3'd0,
      STORE_2 = 3'd1,
      LOAD_1  = 3'd2,
      LOAD_2  = 3'd3,
      ALU_1   = 3'd4,
      ALU_2   = 3'd5,
      INVALID = 3'd7
   } RS_tag_type;

   typedef struct packed {
      logic                  valid;
      RS_tag_type            tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo NUM_RS.
module cdb_arbiter_rr_picker #(
   parameter int unsigned NUM_RS = 6,
   parameter int unsigned IDX_W  = 3
) (
   input  logic [NUM_RS-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_RS-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              any_o
);

   int unsigned      cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < NUM_RS; k++) begin
         cand = 32'(ptr_i) + k;
         if (cand >= NUM_RS) begin
            cand = cand - NUM_RS;
         end
         cand_idx = IDX_W'(cand);
         if (!any_o && req_i[cand_idx]) begin
            any_o           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: grants one RS per cycle and broadcasts its result on a registered CDB.
module cdb_arbiter #(
   parameter int unsigned NUM_RS = 6,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                           CLK,
   input  logic                           RST_N,
   input  logic [NUM_RS-1:0]              REQ,
   input  logic [NUM_RS-1:0][DATA_W-1:0]  RESULT,
   input  logic                           FLUSH,
   output logic [NUM_RS-1:0]              GNT,
   output logic                           CDB_VALID,
   output cdb_arbiter_pkg::RS_tag_type    CDB_TAG,
   output logic [DATA_W-1:0]              CDB_DATA,
   output logic [CNT_W-1:0]               CONFLICT_CNT
);

   import cdb_arbiter_pkg::*;

   localparam int unsigned PTR_W = $clog2(NUM_RS);

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              valid_q, valid_d;
   RS_tag_type        tag_q, tag_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [NUM_RS-1:0] pick_gnt;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_any;
   logic              grant;
   logic              conflict;

   cdb_arbiter_rr_picker #(
      .NUM_RS (NUM_RS),
      .IDX_W  (PTR_W)
   ) u_rr_picker (
      .req_i  (REQ),
      .ptr_i  (ptr_q),
      .gnt_o  (pick_gnt),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   // FLUSH and reset both suppress the grant without disturbing the pointer.
   assign grant    = pick_any && !FLUSH;
   assign GNT      = (RST_N && !FLUSH) ? pick_gnt : '0;
   // Clearing the lowest set bit leaves something only when two or more requests are up.
   assign conflict = |(REQ & (REQ - NUM_RS'(1)));

   always_comb begin
      ptr_d   = ptr_q;
      valid_d = 1'b0;
      tag_d   = tag_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (grant) begin
         ptr_d   = (pick_idx == PTR_W'(NUM_RS - 1)) ? '0 : pick_idx + PTR_W'(1);
         valid_d = 1'b1;
         tag_d   = RS_tag_type'(pick_idx);
         data_d  = RESULT[pick_idx];
      end
      if (!FLUSH && conflict && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         tag_q   <= INVALID;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign CDB_VALID    = valid_q;
   assign CDB_TAG      = tag_q;
   assign CDB_DATA     = data_q;
   assign CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed request vectors push expected broadcasts, a negedge monitor checks the CDB.
module tb_cdb_arbiter;

   import cdb_arbiter_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic                      CLK = 1'b0;
   logic                      RST_N;
   logic [NUM_RS-1:0]         REQ;
   logic [NUM_RS-1:0][DW-1:0] RESULT;
   logic                      FLUSH;
   logic [NUM_RS-1:0]         GNT;
   logic                      CDB_VALID;
   RS_tag_type                CDB_TAG;
   logic [DW-1:0]             CDB_DATA;
   logic [CW-1:0]             CONFLICT_CNT;

   logic [NUM_RS-1:0]         s_gnt;
   logic                      s_valid;
   RS_tag_type                s_tag;
   logic [DW-1:0]             s_data;
   logic [1:0]                s_cnt;

   always #5 CLK = ~CLK;

   cdb_arbiter #(.NUM_RS(NUM_RS), .DATA_W(DW), .CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .RESULT(RESULT), .FLUSH(FLUSH),
      .GNT(GNT), .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG), .CDB_DATA(CDB_DATA),
      .CONFLICT_CNT(CONFLICT_CNT)
   );

   // Narrow counter copy so saturation is reachable in a handful of cycles.
   cdb_arbiter #(.NUM_RS(NUM_RS), .DATA_W(DW), .CNT_W(2)) dut_sat (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .RESULT(RESULT), .FLUSH(FLUSH),
      .GNT(s_gnt), .CDB_VALID(s_valid), .CDB_TAG(s_tag), .CDB_DATA(s_data),
      .CONFLICT_CNT(s_cnt)
   );

   typedef struct {
      int unsigned cyc;
      logic [2:0]  tag;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   logic [2:0]  last_tag;
   logic [31:0] last_data;
   logic        exp_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] onehot_idx(input logic [5:0] oh);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 6; i++) if (oh[i]) r = 3'(i);
      return r;
   endfunction

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: CDB must carry the queued entry stamped for this cycle, else hold the last broadcast.
   always @(negedge CLK) begin
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (!RST_N) begin
         last_tag  = 3'd7;
         last_data = 32'd0;
      end
      if (exp_v) begin
         last_tag  = sb[0].tag;
         last_data = sb[0].data;
         void'(sb.pop_front());
      end
      chk("cdb_valid", 32'(CDB_VALID), 32'(exp_v));
      chk("cdb_tag", 32'(CDB_TAG), 32'(last_tag));
      chk("cdb_data", CDB_DATA, last_data);
   end

   // One arbitration cycle: called and returns at posedge+1.
   task automatic cycle(input logic [5:0] req, input logic fl, input logic [5:0] exp_gnt,
                        input logic [31:0] seed);
      logic [2:0] w;
      REQ   = req;
      FLUSH = fl;
      for (int i = 0; i < NUM_RS; i++) RESULT[i] = seed + 32'(i) * 32'h0101_0101;
      #1;
      chk("gnt", 32'(GNT), 32'(exp_gnt));
      if (exp_gnt != 6'd0) begin
         w = onehot_idx(exp_gnt);
         sb.push_back(exp_t'{cyc + 1, w, RESULT[w]});
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_cnt(input logic [15:0] exp_main, input logic [1:0] exp_sat);
      chk("conflict_cnt", 32'(CONFLICT_CNT), 32'(exp_main));
      chk("conflict_cnt_sat", 32'(s_cnt), 32'(exp_sat));
   endtask

   initial begin
      last_tag  = 3'd7;
      last_data = 32'd0;
      RST_N     = 1'b0;
      REQ       = 6'b111111;
      FLUSH     = 1'b0;
      RESULT    = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_gnt", 32'(GNT), 32'd0);
      chk("rst_valid", 32'(CDB_VALID), 32'd0);
      chk("rst_tag", 32'(CDB_TAG), 32'd7);
      chk("rst_data", CDB_DATA, 32'd0);
      chk_cnt(16'd0, 2'd0);
      REQ   = '0;
      RST_N = 1'b1;

      // Single request from LOAD_1
      cycle(6'b000100, 1'b0, 6'b000100, 32'hDCAB_BCED);
      chk("t1_valid", 32'(CDB_VALID), 32'd1);
      chk("t1_tag", 32'(CDB_TAG), 32'(LOAD_1));
      chk("t1_data", CDB_DATA, 32'hDEAD_BEEF);
      // Pointer now 3: RS3 beats RS0
      cycle(6'b001001, 1'b0, 6'b001000, 32'h1000_0000);
      chk_cnt(16'd1, 2'd1);
      cycle(6'b010000, 1'b0, 6'b010000, 32'h2000_0000);
      chk_cnt(16'd1, 2'd1);
      // Wrap: pointer 5 serves 5 then 0
      cycle(6'b100001, 1'b0, 6'b100000, 32'h3000_0000);
      chk_cnt(16'd2, 2'd2);
      cycle(6'b100001, 1'b0, 6'b000001, 32'h4000_0000);
      chk_cnt(16'd3, 2'd3);
      cycle(6'b000011, 1'b0, 6'b000010, 32'h5000_0000);
      chk_cnt(16'd4, 2'd3);
      // Flush blocks grants and conflict counting, pointer stays at 2
      cycle(6'b010000, 1'b1, 6'b000000, 32'h6000_0000);
      cycle(6'b111111, 1'b1, 6'b000000, 32'h7000_0000);
      chk_cnt(16'd4, 2'd3);
      cycle(6'b010000, 1'b0, 6'b010000, 32'h8000_0000);
      cycle(6'b100100, 1'b0, 6'b100000, 32'h9000_0000);
      chk_cnt(16'd5, 2'd3);
      cycle(6'b111111, 1'b0, 6'b000001, 32'hA000_0000);
      chk_cnt(16'd6, 2'd3);
      chk("pre_rst_valid", 32'(CDB_VALID), 32'd1);

      // Asynchronous reset mid-broadcast with requests still up
      RST_N = 1'b0;
      sb.delete();
      #1;
      chk("arst_gnt", 32'(GNT), 32'd0);
      chk("arst_valid", 32'(CDB_VALID), 32'd0);
      chk("arst_tag", 32'(CDB_TAG), 32'd7);
      chk("arst_data", CDB_DATA, 32'd0);
      chk_cnt(16'd0, 2'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      // All six requesting: strict rotation from RS0
      for (int k = 0; k < 12; k++) begin
         cycle(6'b111111, 1'b0, 6'(1 << (k % 6)), 32'hB000_0000 + 32'(k));
      end
      chk_cnt(16'd12, 2'd3);

      cycle(6'b000000, 1'b0, 6'b000000, 32'h0);
      @(negedge CLK);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) among the six reservation stations of the out-of-order OTTER core. Each RS that has a finished result raises a request; the arbiter grants at most one per cycle and broadcasts the winner's tag and value on a registered CDB to the rename table, the ROB and all RS operand-capture logic. It sits between the execute/RS stage and writeback, downstream of the issue/dispatch logic that fills the RSs.

## Interface
Parameters:
- NUM_RS, 6, number of requesters; fixed by the RS_tag_type encoding
- DATA_W, 32, result width
- CNT_W, 16, width of the conflict counter

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ  in  NUM_RS  per-RS request; bit i is the RS with tag value i
- RESULT  in  NUM_RS x DATA_W  per-RS result; valid whenever the matching REQ bit is high
- FLUSH  in  1  mispredict squash; blocks all grants and clears the CDB
- GNT  out  NUM_RS  one-hot grant, combinational, same cycle as REQ
- CDB_VALID  out  1  broadcast valid
- CDB_TAG  out  RS_tag_type  tag of the broadcasting RS
- CDB_DATA  out  DATA_W  broadcast value
- CONFLICT_CNT  out  CNT_W  saturating count of cycles with 2+ requests

## Operation
- Requester i raises REQ[i] with a stable RESULT[i]. It holds both until it samples GNT[i]=1 at a rising edge, then drops REQ[i] in the next cycle unless a new result is ready.
- Priority pointer PTR (0..5): the search order is PTR, PTR+1, … mod 6. The first requester set wins. GNT has at most one bit set. GNT=0 when REQ=0 or FLUSH=1.
- On a grant to i: PTR <= (i+1) mod 6, so i=5 wraps to 0. With no grant, PTR holds. FLUSH does not change PTR.
- CDB register: on a grant, CDB_VALID<=1, CDB_TAG<=i, CDB_DATA<=RESULT[i]. Otherwise CDB_VALID<=0, and TAG and DATA hold their last values.
- FLUSH=1 for cycle N: no grant in N, CDB_VALID=0 in N+1. A broadcast already visible in cycle N completes normally. Requesters handle their own squash.
- CONFLICT_CNT increments by 1 in each cycle with popcount(REQ)≥2 and FLUSH=0. It saturates at all-ones and is cleared only by reset.
- RST_N low, asynchronous: PTR=0, CDB_VALID=0, CDB_TAG=INVALID, CDB_DATA=0, CONFLICT_CNT=0. GNT=0 while reset is asserted. Deasserting reset mid-request gives a normal grant on the first cycle after release.

## Timing
- Request-to-grant latency is 0 cycles: combinational GNT in cycle N.
- Grant-to-broadcast latency is 1 cycle: CDB fields are valid in N+1 for exactly one cycle.
- Throughput is one broadcast per cycle. Back-to-back grants to different RSs give consecutive CDB_VALID cycles.
- With all 6 requesting continuously, each RS is granted once every 6 cycles, in order PTR, PTR+1, …. Worst-case wait is 5 cycles.
- There is no combinational path from any input to CDB_* or CONFLICT_CNT.

## Structure
- cpu_types package:
  - RS_tag_type is a 3-bit enum: STORE_1=0, STORE_2=1, LOAD_1=2, LOAD_2=3, ALU_1=4, ALU_2=5, INVALID=7.
  - Add a cdb_t struct {valid, tag, data} and the constant NUM_RS=6.
- Sub-module rr_picker: purely combinational, takes REQ and PTR, returns one-hot GNT and the encoded winner index. cdb_arbiter owns PTR, the CDB register and the counter.

## Test plan
- Reset, then REQ=6'b000100 with RESULT[2]=32'hDEAD_BEEF -> GNT=6'b000100 in the same cycle; next cycle CDB_VALID=1, CDB_TAG=LOAD_1, CDB_DATA=32'hDEAD_BEEF; PTR=3.
- All six REQ held high for 12 cycles from reset -> grants in order 0,1,2,3,4,5,0,1,…; CDB_VALID high every cycle from cycle 2; CONFLICT_CNT=12.
- Wrap: PTR=5 (after granting 4), REQ=6'b100001 -> grant 5, then grant 0; PTR ends at 1.
- FLUSH high for one cycle with REQ=6'b010000 -> GNT=0 and CDB_VALID=0 next cycle; the cycle after FLUSH drops, grant 4 with PTR unchanged by the flush.
- RST_N pulsed low mid-stream while CDB_VALID=1 -> outputs go to reset values immediately (asynchronously); after release, PTR=0 and arbitration restarts from RS 0.
- Force CONFLICT_CNT to 16'hFFFE, then 3 conflict cycles -> the counter holds at 16'hFFFF.
